// File: rtl/dma_dev_arbiter.sv
// dma_dev_arbiter: shares one dma_controller device port among NUM_CH devices, round-robin unless DMA_ARB_FIXED_PRIO_EN selects fixed priority
module dma_dev_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADD_LEN = 16,
  parameter int DATA_LEN = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_rqst,
  input  logic [NUM_CH-1:0]           ch_rd_wr,
  input  logic [NUM_CH*ADD_LEN-1:0]   ch_num_words,
  input  logic [NUM_CH*(ADD_LEN+1)-1:0] ch_start_addr,
  input  logic [NUM_CH-1:0]           ch_dev_ack,
  input  logic [NUM_CH*DATA_LEN-1:0]  ch_dev_in,
  output logic [NUM_CH-1:0]           ch_grant,
  output logic [NUM_CH-1:0]           ch_dma_ack,
  output logic [NUM_CH-1:0]           ch_end_flag,
  output logic [DATA_LEN-1:0]         dev_out,
  output logic                        busy,
  output logic [$clog2(NUM_CH)-1:0]   grant_id,
  output logic                        dma_rqst,
  output logic                        dma_rd_wr,
  output logic [ADD_LEN-1:0]          dma_num_words,
  output logic [ADD_LEN:0]            dma_start_addr,
  output logic                        dma_dev_ack,
  output logic [DATA_LEN-1:0]         dma_dev_in,
  input  logic                        dma_ack,
  input  logic                        dma_end_flag,
  input  logic [DATA_LEN-1:0]         dma_dev_out
);
  localparam int IW = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, REQ, BUSY, RELEASE} state_t;
  state_t state, state_nx;
  logic [NUM_CH-1:0] rqst_q, pending, grant, win_oh;
  logic [IW-1:0] win, idx;
  logic [DATA_LEN-1:0] dev_in_a [NUM_CH];
  logic [ADD_LEN-1:0] nw_a [NUM_CH];
  logic [ADD_LEN:0] sa_a [NUM_CH];
  logic go, in_busy;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign dev_in_a[i] = ch_dev_in[i*DATA_LEN +: DATA_LEN];
    assign nw_a[i] = ch_num_words[i*ADD_LEN +: ADD_LEN];
    assign sa_a[i] = ch_start_addr[i*(ADD_LEN+1) +: ADD_LEN+1];
  end
`ifdef DMA_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = IW'(i);
      if (pending[idx]) win = idx;
    end
  end
`else
  logic [IW-1:0] last;
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_CH);
      if (pending[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= IW'(NUM_CH - 1);
    else if (state == RELEASE) last <= grant_id;
`endif
  assign go = state == IDLE && |pending;
  assign win_oh = NUM_CH'(1) << win;
  assign in_busy = state == BUSY;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = go ? REQ : state == REQ ? BUSY : (in_busy && dma_end_flag) ? RELEASE : state == RELEASE ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rqst_q <= '0;
      pending <= '0;
      grant <= '0;
      grant_id <= '0;
      dma_rd_wr <= 1'b0;
      dma_num_words <= '0;
      dma_start_addr <= '0;
    end else begin
      rqst_q <= ch_rqst;
      pending <= (pending & ~(go ? win_oh : '0)) | (ch_rqst & ~rqst_q);
      grant <= go ? win_oh : state == RELEASE ? '0 : grant;
      if (go) begin
        grant_id <= win;
        dma_rd_wr <= ch_rd_wr[win];
        dma_num_words <= nw_a[win];
        dma_start_addr <= sa_a[win];
      end
    end
  assign busy = state != IDLE;
  assign dma_rqst = state == REQ;
  assign ch_grant = grant;
  assign ch_end_flag = state == RELEASE ? grant : '0;
  assign ch_dma_ack = (in_busy && dma_ack) ? grant : '0;
  assign dma_dev_ack = in_busy && ch_dev_ack[grant_id];
  assign dma_dev_in = in_busy ? dev_in_a[grant_id] : '0;
  assign dev_out = dma_dev_out;
endmodule

// File: tb/tb_dma_dev_arbiter.sv
// tb_dma_dev_arbiter: randomized scoreboard bench acting as devices and dma_controller around dma_dev_arbiter
module tb_dma_dev_arbiter;
  localparam int N = 4, AL = 16, DL = 16, IW = $clog2(N);
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] ch_rqst = '0, ch_rd_wr = '0, ch_dev_ack = '0;
  logic [N*AL-1:0] ch_num_words = '0;
  logic [N*(AL+1)-1:0] ch_start_addr = '0;
  logic [N*DL-1:0] ch_dev_in = '0;
  logic [N-1:0] ch_grant, ch_dma_ack, ch_end_flag;
  logic [DL-1:0] dev_out, dma_dev_in, dma_dev_out = '0;
  logic busy, dma_rqst, dma_rd_wr, dma_dev_ack, dma_ack = 1'b0, dma_end_flag = 1'b0;
  logic [IW-1:0] grant_id;
  logic [AL-1:0] dma_num_words;
  logic [AL:0] dma_start_addr;
  int checks = 0, failures = 0, cyc = 0, last_rq = -100, ref_g = N - 1, mg, me;
  int exp_q[$], end_q[$];
  bit cfg_rd [N];
  int cfg_nw [N];
  logic [AL:0] cfg_sa [N];
  dma_dev_arbiter #(.NUM_CH(N), .ADD_LEN(AL), .DATA_LEN(DL)) dut (
    .clk(clk), .reset(reset), .ch_rqst(ch_rqst), .ch_rd_wr(ch_rd_wr),
    .ch_num_words(ch_num_words), .ch_start_addr(ch_start_addr),
    .ch_dev_ack(ch_dev_ack), .ch_dev_in(ch_dev_in), .ch_grant(ch_grant),
    .ch_dma_ack(ch_dma_ack), .ch_end_flag(ch_end_flag), .dev_out(dev_out),
    .busy(busy), .grant_id(grant_id), .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
    .dma_num_words(dma_num_words), .dma_start_addr(dma_start_addr),
    .dma_dev_ack(dma_dev_ack), .dma_dev_in(dma_dev_in), .dma_ack(dma_ack),
    .dma_end_flag(dma_end_flag), .dma_dev_out(dma_dev_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic chk_reset_outs();
    chk("rst_ctrl", {ch_grant, ch_dma_ack, ch_end_flag, busy, grant_id, dma_rqst, dma_rd_wr, dma_dev_ack}, 0);
    chk("rst_params", {dma_num_words, dma_start_addr}, 0);
    chk("rst_dev_in", dma_dev_in, 0);
  endtask
  task automatic set_cfg(input int c, input bit rd, input int nw, input logic [AL:0] sa);
    cfg_rd[c] = rd;
    cfg_nw[c] = nw;
    cfg_sa[c] = sa;
    ch_rd_wr[c] = rd;
    ch_num_words[c*AL +: AL] = AL'(nw);
    ch_start_addr[c*(AL+1) +: AL+1] = sa;
  endtask
  task automatic rand_dev_in();
    for (int c = 0; c < N; c++) ch_dev_in[c*DL +: DL] = DL'($urandom);
  endtask
  // Expected grant order: the set of outstanding channels ordered from the reference grant.
  task automatic req_model(input logic [N-1:0] m, input bit rnd);
    bit [N-1:0] s = '0;
    foreach (exp_q[i]) s[exp_q[i]] = 1'b1;
    for (int c = 0; c < N; c++)
      if (m[c] && !s[c] && rnd) set_cfg(c, 1'($urandom), $urandom_range(0, 4), (AL+1)'($urandom));
    s |= m;
    exp_q.delete();
`ifdef DMA_ARB_FIXED_PRIO_EN
    for (int c = 0; c < N; c++) if (s[c]) exp_q.push_back(c);
`else
    for (int k = 1; k <= N; k++) if (s[(ref_g + k) % N]) exp_q.push_back((ref_g + k) % N);
`endif
  endtask
  task automatic pulse(input logic [N-1:0] m, input bit rnd);
    req_model(m, rnd);
    ch_rqst = ch_rqst | m;
    @(negedge clk);
    ch_rqst = ch_rqst & ~m;
    @(negedge clk);
  endtask
  task automatic xfer(input logic [N-1:0] side, input bit rst_mid);
    int n = 0, g, nw;
    while (!dma_rqst && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dma_rqst) begin
      checks++;
      failures++;
      $display("FAIL rqst_timeout actual=no dma_rqst required=dma_rqst within 20 cycles");
      exp_q.delete();
      return;
    end
    #1;
    g = ref_g;
    nw = cfg_nw[g];
    dma_ack = 1'b1;
    ch_dev_ack = '1;
    rand_dev_in();
    #1;
    chk("req_gating", {ch_dma_ack, dma_dev_ack, dma_dev_in}, 0);
    dma_ack = 1'b0;
    ch_dev_ack = '0;
    @(negedge clk);
    if (side != 0) begin
      pulse(side, 1);
      if ($urandom_range(0, 1) == 1) pulse(side, 1);
    end
    if (rst_mid) begin
      reset = 1'b1;
      #1;
      chk_reset_outs();
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      end_q.delete();
      ref_g = N - 1;
      return;
    end
    for (int i = 0; i < nw; i++) begin
      dma_ack = 1'($urandom);
      ch_dev_ack = N'($urandom);
      rand_dev_in();
      dma_dev_out = DL'($urandom);
      #1;
      chk("ch_dma_ack", ch_dma_ack, dma_ack ? (1 << g) : 0);
      chk("dma_dev_ack", dma_dev_ack, ch_dev_ack[g]);
      chk("dma_dev_in", dma_dev_in, ch_dev_in[g*DL +: DL]);
      chk("dev_out", dev_out, dma_dev_out);
      chk("busy_grant", {busy, ch_grant}, {1'b1, N'(1 << g)});
      @(negedge clk);
    end
    dma_ack = 1'b0;
    ch_dev_ack = '0;
    dma_end_flag = 1'b1;
    @(negedge clk);
    dma_end_flag = 1'b0;
    dma_ack = 1'b1;
    ch_dev_ack = '1;
    rand_dev_in();
    #1;
    chk("rel_gating", {ch_dma_ack, dma_dev_ack, dma_dev_in}, 0);
    chk("rel_busy", busy, 1);
    dma_ack = 1'b0;
    ch_dev_ack = '0;
    @(negedge clk);
    chk("idle_state", {busy, ch_grant}, 0);
  endtask
  always @(negedge clk) begin
    if (!reset && dma_rqst) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_unexpected actual=grant_id %0d required=no dma_rqst", grant_id);
      end else begin
        mg = exp_q.pop_front();
        ref_g = mg;
        end_q.push_back(mg);
        chk("grant_id", grant_id, mg);
        chk("ch_grant", ch_grant, 1 << mg);
        chk("dma_rd_wr", dma_rd_wr, cfg_rd[mg]);
        chk("dma_num_words", dma_num_words, cfg_nw[mg]);
        chk("dma_start_addr", dma_start_addr, cfg_sa[mg]);
        chk("rqst_spacing", (cyc - last_rq) >= 4, 1);
        last_rq = cyc;
      end
    end
    if (!reset && ch_end_flag != 0) begin
      if (end_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL end_unexpected actual=ch_end_flag %0h required=0", ch_end_flag);
      end else begin
        me = end_q.pop_front();
        chk("ch_end_flag", ch_end_flag, 1 << me);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outs();
    reset = 1'b0;
    @(negedge clk);
    pulse(4'b1011, 1);
    xfer('0, 0);
    xfer(4'b0001, 0);
    while (exp_q.size() > 0) xfer('0, 0);
    set_cfg(2, 1, 4, 17'h0200);
    req_model(4'b0100, 0);
    ch_rqst[2] = 1'b1;
    @(negedge clk);
    chk("rqst_early", dma_rqst, 0);
    ch_rqst[2] = 1'b0;
    @(negedge clk);
    chk("rqst_latency", dma_rqst, 1);
    xfer('0, 0);
    set_cfg(1, 0, 3, 17'h0404);
    pulse(4'b0010, 0);
    xfer('0, 0);
    set_cfg(3, 1, 0, 17'h0100);
    pulse(4'b1000, 0);
    xfer('0, 0);
    set_cfg(2, 1, 3, 17'h0300);
    pulse(4'b0100, 0);
    xfer(4'b0010, 1);
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_idle", {busy, dma_rqst, ch_grant}, 0);
    end
    set_cfg(0, 0, 2, 17'h0010);
    pulse(4'b0001, 0);
    xfer('0, 0);
    repeat (40) begin
      pulse(N'($urandom_range(1, 2**N - 1)), 1);
      while (exp_q.size() > 0) xfer(($urandom_range(0, 2) == 0) ? N'($urandom) : '0, 0);
    end
    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("end_q_empty", end_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
